// File: rtl/cpu_pkg.sv
// Shared interrupt-sequencer types: FSM state encoding and default vector table placement.
// Pure declarations; no logic, no latency, no flow control.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    PUSH    = 3'd2,
    VECTOR  = 3'd3,
    SERVICE = 3'd4
  } irq_state_t;

  localparam int unsigned VEC_BASE_DEFAULT   = 32'h0000;
  localparam int unsigned VEC_STRIDE_DEFAULT = 32'd2;
  localparam int unsigned DRAIN_CNT_W        = 3;

endpackage

// File: rtl/irq_pending_bank.sv
// Edge detect + sticky pending bits + fixed-priority pick (index 0 wins); pending lands one clock after the edge.
// Never stalls: keeps sampling every clock; a bit clears only on its own ack.
module irq_pending_bank
  import cpu_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic [NUM_IRQ-1:0] ack,
  output logic               sel_vld,
  output logic [ID_W-1:0]    sel_id,
  output logic [NUM_IRQ-1:0] pending
);

  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] cand;

  assign rise = irq & ~prev;
  // Fresh edges are eligible in the same clock they are latched, so DRAIN starts alongside pending.
  assign cand = (pending | rise) & ~mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= '0;
      pending <= '0;
    end else begin
      prev    <= irq;
      pending <= (pending & ~ack) | rise;
    end
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_vld = 1'b1;
        sel_id  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt front-end: waits for a boundary, drains DRAIN_CYCLES bubbles, pushes, vectors, blocks until RTI.
// i_stall freezes state/counter and masks the push/ack/vector pulses for that cycle; pending keeps sampling.
module interrupt_sequencer
  import cpu_pkg::*;
#(
  parameter int          NUM_IRQ      = 4,
  parameter int          ADDR_W       = 16,
  parameter int unsigned VEC_BASE     = VEC_BASE_DEFAULT,
  parameter int unsigned VEC_STRIDE   = VEC_STRIDE_DEFAULT,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_irq_mask,
  input  logic               i_stall,
  input  logic               i_boundary,
  input  logic               i_rti,
  output logic               o_bubble,
  output logic               o_interrupt,
  output logic               o_vector_valid,
  output logic [ADDR_W-1:0]  o_vector_addr,
  output logic [NUM_IRQ-1:0] o_irq_ack,
  output logic               o_in_service,
  output logic [NUM_IRQ-1:0] o_pending
);

  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  irq_state_t             state;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic [ID_W-1:0]        cur_id;
  logic                   sel_vld;
  logic [ID_W-1:0]        sel_id;
  logic [ADDR_W-1:0]      vec_addr;

  irq_pending_bank #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_bank (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .irq     (i_irq),
    .mask    (i_irq_mask),
    .ack     (o_irq_ack),
    .sel_vld (sel_vld),
    .sel_id  (sel_id),
    .pending (o_pending)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      cur_id    <= '0;
    end else if (!i_stall) begin
      case (state)
        IDLE: begin
          if (sel_vld && i_boundary) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_CNT_W'(DRAIN_CYCLES - 1);
            cur_id    <= sel_id;
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= PUSH;
          else drain_cnt <= drain_cnt - 1'b1;
        end
        PUSH:    state <= VECTOR;
        VECTOR:  state <= SERVICE;
        SERVICE: if (i_rti) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign vec_addr = ADDR_W'(VEC_BASE) + ADDR_W'(cur_id) * ADDR_W'(VEC_STRIDE);

  assign o_bubble       = (state == DRAIN) || (state == PUSH) || (state == VECTOR);
  assign o_in_service   = (state == SERVICE);
  // The stall gate is the only input reaching an output; it keeps the ack a single pulse.
  assign o_interrupt    = (state == PUSH) && !i_stall;
  assign o_vector_valid = (state == VECTOR) && !i_stall;
  assign o_vector_addr  = (state == VECTOR) ? vec_addr : '0;
  assign o_irq_ack      = o_interrupt ? (NUM_IRQ'(1) << cur_id) : '0;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: vector table, stall/reset corner sequences, random run vs. phase model.
module tb_interrupt_sequencer;

  localparam int N      = 4;
  localparam int AW     = 16;
  localparam int D      = 2;
  localparam int BASE   = 0;
  localparam int STRIDE = 2;
  localparam int OW     = 3 + AW + N + 1 + N;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq   = '0;
  logic [N-1:0]  mask  = '0;
  logic          stall = 1'b0;
  logic          bnd   = 1'b0;
  logic          rti   = 1'b0;
  logic          bubble, interrupt, vector_valid, in_service;
  logic [AW-1:0] vector_addr;
  logic [N-1:0]  irq_ack, pending;

  interrupt_sequencer #(
    .NUM_IRQ(N), .ADDR_W(AW), .VEC_BASE(BASE), .VEC_STRIDE(STRIDE), .DRAIN_CYCLES(D)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_irq          (irq),
    .i_irq_mask     (mask),
    .i_stall        (stall),
    .i_boundary     (bnd),
    .i_rti          (rti),
    .o_bubble       (bubble),
    .o_interrupt    (interrupt),
    .o_vector_valid (vector_valid),
    .o_vector_addr  (vector_addr),
    .o_irq_ack      (irq_ack),
    .o_in_service   (in_service),
    .o_pending      (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0]  irq;
    logic [N-1:0]  mask;
    logic          bnd;
    logic          rti;
    logic [OW-1:0] exp;
  } vec_t;
  vec_t tbl[$];

  // Reference model: a single phase number 0=idle, 1..D=drain, D+1=push, D+2=vector, D+3=service.
  logic [N-1:0] m_pend, m_prev;
  int           phase, cur;

  function automatic logic [OW-1:0] pk(input logic bub, input logic intr, input logic vv,
                                       input logic [AW-1:0] addr, input logic [N-1:0] ack,
                                       input logic svc, input logic [N-1:0] pnd);
    return {bub, intr, vv, addr, ack, svc, pnd};
  endfunction

  function automatic logic [OW-1:0] actual();
    return pk(bubble, interrupt, vector_valid, vector_addr, irq_ack, in_service, pending);
  endfunction

  task automatic add(input logic [N-1:0] i, input logic [N-1:0] m, input logic b, input logic r,
                     input logic [OW-1:0] e);
    vec_t v;
    v.irq = i; v.mask = m; v.bnd = b; v.rti = r; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [OW-1:0] exp);
    n_checks++;
    if (actual() !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %h, expected %h", name, actual(), exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 4 units after it.
  task automatic apply(input logic [N-1:0] i, input logic [N-1:0] m, input logic s,
                       input logic b, input logic r);
    @(posedge clk);
    #1;
    irq = i; mask = m; stall = s; bnd = b; rti = r;
    #3;
  endtask

  function automatic logic [OW-1:0] model_out(input logic s);
    logic          intr, vv;
    logic [AW-1:0] addr;
    logic [N-1:0]  ack;
    intr = (phase == D + 1) && !s;
    vv   = (phase == D + 2) && !s;
    addr = (phase == D + 2) ? AW'(BASE + cur * STRIDE) : '0;
    ack  = intr ? N'(1 << cur) : '0;
    return pk((phase >= 1) && (phase <= D + 2), intr, vv, addr, ack, phase == D + 3, m_pend);
  endfunction

  task automatic model_step();
    logic [N-1:0] rise, avail, ack;
    bit           found;
    rise   = irq & ~m_prev;
    avail  = (m_pend | rise) & ~mask;
    ack    = ((phase == D + 1) && !stall) ? N'(1 << cur) : '0;
    m_pend = (m_pend & ~ack) | rise;
    m_prev = irq;
    if (!stall) begin
      if (phase == 0) begin
        if (avail != '0 && bnd) begin
          phase = 1;
          found = 1'b0;
          for (int i = 0; i < N; i++) begin
            if (avail[i] && !found) begin
              cur   = i;
              found = 1'b1;
            end
          end
        end
      end else if (phase == D + 3) begin
        if (rti) phase = 0;
      end else begin
        phase = phase + 1;
      end
    end
  endtask

  localparam logic [AW-1:0] Z = '0;

  initial begin
    int push_at, ack_cnt;
    logic [N-1:0] ack_seen, ni, nm;

    // irq, mask, boundary, rti | bubble, interrupt, vector_valid, addr, ack, in_service, pending
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h0));
    add(4'h4, 4'h0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h0));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h4));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h4));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b1, 1'b1, 1'b0, Z,      4'h4, 1'b0, 4'h4));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b1, 16'h4,  4'h0, 1'b0, 4'h0));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b1, 4'h0));
    add(4'h1, 4'h0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b1, 4'h0));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b1, 4'h1));
    add(4'h0, 4'h0, 1'b1, 1'b1, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b1, 4'h1));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h1));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h1));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h1));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b1, 1'b1, 1'b0, Z,      4'h1, 1'b0, 4'h1));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b1, 16'h0,  4'h0, 1'b0, 4'h0));
    add(4'h0, 4'h0, 1'b1, 1'b1, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b1, 4'h0));
    add(4'hA, 4'h2, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h0));
    add(4'h0, 4'h2, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'hA));
    add(4'h0, 4'h2, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'hA));
    add(4'h0, 4'h2, 1'b1, 1'b0, pk(1'b1, 1'b1, 1'b0, Z,      4'h8, 1'b0, 4'hA));
    add(4'h0, 4'h2, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b1, 16'h6,  4'h0, 1'b0, 4'h2));
    add(4'h0, 4'h2, 1'b1, 1'b1, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b1, 4'h2));
    add(4'h0, 4'h2, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h2));
    add(4'h0, 4'h0, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h2));
    add(4'h0, 4'h0, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h2));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h2));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h2));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h2));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b1, 1'b1, 1'b0, Z,      4'h2, 1'b0, 4'h2));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b1, 1'b0, 1'b1, 16'h2,  4'h0, 1'b0, 4'h0));
    add(4'h0, 4'h0, 1'b1, 1'b1, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b1, 4'h0));
    add(4'h0, 4'h0, 1'b1, 1'b0, pk(1'b0, 1'b0, 1'b0, Z,      4'h0, 1'b0, 4'h0));

    #2;
    check("reset_hold", '0);
    #10;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].irq, tbl[i].mask, 1'b0, tbl[i].bnd, tbl[i].rti);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Three stall cycles inside DRAIN push the PUSH from offset 3 to offset 6.
    push_at  = -1;
    ack_cnt  = 0;
    ack_seen = '0;
    apply(4'h1, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      apply(4'h0, 4'h0, (c >= 2 && c <= 4), 1'b1, 1'b0);
      if (irq_ack != '0) begin
        ack_cnt++;
        ack_seen = irq_ack;
      end
      if (interrupt && push_at < 0) push_at = c;
      if (c == 3) check_val("stall_bubble", 32'(bubble), 32'd1);
    end
    check_val("stall_push_at", push_at, 32'd6);
    check_val("stall_ack_count", ack_cnt, 32'd1);
    check_val("stall_ack_value", 32'(ack_seen), 32'h1);
    apply(4'h0, 4'h0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset while in VECTOR, released with irq[1] held high.
    apply(4'h8, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) apply(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    check("rst_in_vector", pk(1'b1, 1'b0, 1'b1, 16'h6, 4'h0, 1'b0, 4'h0));
    #2;
    rst_n = 1'b0;
    irq   = 4'h2;
    #1;
    check("rst_async", '0);
    @(posedge clk);
    #1;
    check("rst_held", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_release_pend", 32'(pending), 32'h2);

    @(negedge clk);
    rst_n = 1'b0;
    irq = '0; mask = '0; stall = 1'b0; bnd = 1'b0; rti = 1'b0;
    m_pend = '0; m_prev = '0; phase = 0; cur = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 1500; c++) begin
      ni = irq ^ (N'($urandom) & N'($urandom));
      nm = ($urandom_range(0, 15) == 0) ? N'($urandom) : mask;
      apply(ni, nm, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) == 0));
      check($sformatf("rand%0d", c), model_out(stall));
      model_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
